// File: rtl/recovery_sequencer.sv
// ============================================================================
// recovery_sequencer
// ----------------------------------------------------------------------------
// Sequences pipeline recovery after a commit-stage flush. A flush (mispredict
// redirect or exception) kills speculative state. An exception flush also
// waits for the committed-store buffer to drain, bounded by a timeout. The
// committed RAT is then copied into the speculative RAT RESTORE_W lanes per
// cycle, the free list is told to rebuild, and fetch is redirected with a
// valid/ready handshake. While busy this block owns the speculative-RAT
// write port.
//
// State sequence: IDLE -> KILL -> [DRAIN] -> RESTORE x N -> REBUILD -> REDIRECT
//
// Ports
//   clk, reset_n           clock (rising edge), asynchronous active-low reset
//   flush_req              1-cycle flush pulse from commit
//   flush_is_exception     1 = exception flush (store drain required)
//   flush_target_pc        restart PC, sampled with flush_req
//   lsu_sb_empty           committed-store buffer is empty
//   crat_raddr             base arch index for the committed-RAT read
//   crat_rdata[RESTORE_W]  committed mappings for crat_raddr+lane (comb.)
//   rat_wen/waddr/wdata    registered speculative-RAT write (lags read by 1)
//   pipe_kill              1-cycle kill of speculative entries
//   freelist_rebuild       1-cycle free-list rebuild pulse
//   frontend_stall         hold fetch/decode/rename while recovering
//   redirect_valid/pc      fetch redirect request, held until redirect_ready
//   redirect_ready         fetch accepts the redirect
//   busy                   sequencer is not idle
//   flush_dropped          1-cycle pulse: a flush arrived while busy
//   drain_timeout          sticky: a store drain was abandoned on timeout
//   perf_recoveries        completed recoveries (wrapping)
// ============================================================================
module recovery_sequencer #(
    parameter int ARCH_REGS     = 32,
    parameter int PHYS_W        = 7,
    parameter int XLEN          = 32,
    parameter int RESTORE_W     = 4,
    parameter int DRAIN_TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush_req,
    input  logic                         flush_is_exception,
    input  logic [XLEN-1:0]              flush_target_pc,
    input  logic                         lsu_sb_empty,
    output logic [$clog2(ARCH_REGS)-1:0] crat_raddr,
    input  logic [PHYS_W-1:0]            crat_rdata [RESTORE_W],
    output logic                         rat_wen,
    output logic [$clog2(ARCH_REGS)-1:0] rat_waddr,
    output logic [PHYS_W-1:0]            rat_wdata [RESTORE_W],
    output logic                         pipe_kill,
    output logic                         freelist_rebuild,
    output logic                         frontend_stall,
    output logic                         redirect_valid,
    output logic [XLEN-1:0]              redirect_pc,
    input  logic                         redirect_ready,
    output logic                         busy,
    output logic                         flush_dropped,
    output logic                         drain_timeout,
    output logic [31:0]                  perf_recoveries
);

    localparam int              IDX_W       = $clog2(ARCH_REGS);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(ARCH_REGS - RESTORE_W);
    localparam logic [IDX_W-1:0] IDX_STEP   = IDX_W'(RESTORE_W);
    localparam logic [7:0]       DRAIN_LIMIT = 8'(DRAIN_TIMEOUT);

    // The restore loop copies whole lane groups only.
    generate
        if (ARCH_REGS % RESTORE_W != 0) begin : g_bad_restore_w
            $error("recovery_sequencer: ARCH_REGS must be a multiple of RESTORE_W");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_KILL     = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_RESTORE  = 3'd3,
        ST_REBUILD  = 3'd4,
        ST_REDIRECT = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              is_exc_q, is_exc_d;
    logic [7:0]        drain_cnt_q, drain_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              drain_timeout_q, drain_timeout_d;
    logic [31:0]       perf_q, perf_d;

    // Write-port stage: the committed-RAT read is combinational, so the
    // speculative-RAT write is issued one cycle later from these registers.
    logic              wen_q;
    logic [IDX_W-1:0]  waddr_q;
    logic [PHYS_W-1:0] wdata_q [RESTORE_W];
    logic              dropped_q;

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        is_exc_d         = is_exc_q;
        drain_cnt_d      = drain_cnt_q;
        idx_d            = idx_q;
        drain_timeout_d  = drain_timeout_q;
        perf_d           = perf_q;
        crat_raddr       = '0;
        pipe_kill        = 1'b0;
        freelist_rebuild = 1'b0;
        redirect_valid   = 1'b0;
        redirect_pc      = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    pc_d     = flush_target_pc;
                    is_exc_d = flush_is_exception;
                    state_d  = ST_KILL;
                end
            end

            ST_KILL: begin
                pipe_kill   = 1'b1;
                drain_cnt_d = '0;
                idx_d       = '0;
                state_d     = is_exc_q ? ST_DRAIN : ST_RESTORE;
            end

            ST_DRAIN: begin
                if (lsu_sb_empty) begin
                    state_d = ST_RESTORE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 8'd1;
                    // Give up once the count of non-empty cycles reaches
                    // the limit; the store buffer is assumed wedged.
                    if (drain_cnt_q + 8'd1 == DRAIN_LIMIT) begin
                        drain_timeout_d = 1'b1;
                        state_d         = ST_RESTORE;
                    end
                end
            end

            ST_RESTORE: begin
                crat_raddr = idx_q;
                idx_d      = idx_q + IDX_STEP;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_REBUILD;
                end
            end

            ST_REBUILD: begin
                // The final lane group is being written this same cycle.
                freelist_rebuild = 1'b1;
                state_d          = ST_REDIRECT;
            end

            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = pc_q;
                if (redirect_ready) begin
                    perf_d  = perf_q + 32'd1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            pc_q            <= '0;
            is_exc_q        <= 1'b0;
            drain_cnt_q     <= '0;
            idx_q           <= '0;
            drain_timeout_q <= 1'b0;
            perf_q          <= '0;
            wen_q           <= 1'b0;
            waddr_q         <= '0;
            dropped_q       <= 1'b0;
            for (int i = 0; i < RESTORE_W; i++) begin
                wdata_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            is_exc_q        <= is_exc_d;
            drain_cnt_q     <= drain_cnt_d;
            idx_q           <= idx_d;
            drain_timeout_q <= drain_timeout_d;
            perf_q          <= perf_d;
            wen_q           <= (state_q == ST_RESTORE);
            waddr_q         <= crat_raddr;
            // A flush seen while recovering is not queued; report it instead.
            dropped_q       <= flush_req && (state_q != ST_IDLE);
            if (state_q == ST_RESTORE) begin
                for (int i = 0; i < RESTORE_W; i++) begin
                    wdata_q[i] <= crat_rdata[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rat_wen         = wen_q;
    assign rat_waddr       = waddr_q;
    assign busy            = (state_q != ST_IDLE);
    assign frontend_stall  = (state_q != ST_IDLE);
    assign flush_dropped   = dropped_q;
    assign drain_timeout   = drain_timeout_q;
    assign perf_recoveries = perf_q;

    for (genvar gi = 0; gi < RESTORE_W; gi++) begin : g_wdata_lane
        assign rat_wdata[gi] = wdata_q[gi];
    end

endmodule

// File: tb/tb_recovery_sequencer.sv
// ============================================================================
// tb_recovery_sequencer
// ----------------------------------------------------------------------------
// Directed bench for recovery_sequencer. A committed-RAT model answers the
// DUT's read port; expected RAT writes and redirect PCs are queued when each
// flush is issued and popped as the DUT produces them. Recovery timing is
// measured in cycles relative to the flush cycle T.
// ============================================================================
module tb_recovery_sequencer;

    localparam int ARCH_REGS = 32;
    localparam int PHYS_W    = 7;
    localparam int XLEN      = 32;
    localparam int RW        = 4;

    typedef struct packed {
        logic [4:0]         addr;
        logic [RW*PHYS_W-1:0] data;
    } wr_t;

    logic              clk;
    logic              reset_n;
    logic              flush_req;
    logic              flush_is_exception;
    logic [XLEN-1:0]   flush_target_pc;
    logic              lsu_sb_empty;
    logic [4:0]        crat_raddr;
    logic [PHYS_W-1:0] crat_rdata [RW];
    logic              rat_wen;
    logic [4:0]        rat_waddr;
    logic [PHYS_W-1:0] rat_wdata [RW];
    logic              pipe_kill;
    logic              freelist_rebuild;
    logic              frontend_stall;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              redirect_ready;
    logic              busy;
    logic              flush_dropped;
    logic              drain_timeout;
    logic [31:0]       perf_recoveries;

    recovery_sequencer #(
        .ARCH_REGS    (ARCH_REGS),
        .PHYS_W       (PHYS_W),
        .XLEN         (XLEN),
        .RESTORE_W    (RW),
        .DRAIN_TIMEOUT(255)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .flush_req         (flush_req),
        .flush_is_exception(flush_is_exception),
        .flush_target_pc   (flush_target_pc),
        .lsu_sb_empty      (lsu_sb_empty),
        .crat_raddr        (crat_raddr),
        .crat_rdata        (crat_rdata),
        .rat_wen           (rat_wen),
        .rat_waddr         (rat_waddr),
        .rat_wdata         (rat_wdata),
        .pipe_kill         (pipe_kill),
        .freelist_rebuild  (freelist_rebuild),
        .frontend_stall    (frontend_stall),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .redirect_ready    (redirect_ready),
        .busy              (busy),
        .flush_dropped     (flush_dropped),
        .drain_timeout     (drain_timeout),
        .perf_recoveries   (perf_recoveries)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Committed-RAT model: combinational read of RW consecutive entries.
    logic [PHYS_W-1:0] crat_mem [ARCH_REGS];
    always_comb begin
        for (int l = 0; l < RW; l++) begin
            crat_rdata[l] = crat_mem[(int'(crat_raddr) + l) % ARCH_REGS];
        end
    end

    int checks = 0;
    int errors = 0;

    wr_t             wr_q[$];
    logic [XLEN-1:0] pc_q[$];

    // Per-recovery observations (cycle numbers relative to flush cycle T)
    int cyc, kill_cyc, n_kill, first_wen, n_wen, first_rebuild;
    int first_redirect, n_redirect, n_dropped, dropped_cyc;
    // Stimulus knobs for the running recovery
    int sb_low, ready_delay, inject_cyc;

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW*PHYS_W-1:0] pack_wdata();
        logic [RW*PHYS_W-1:0] v;
        v = '0;
        for (int l = 0; l < RW; l++) v[l*PHYS_W +: PHYS_W] = rat_wdata[l];
        return v;
    endfunction

    // Sample DUT outputs for the current cycle and check against the scoreboard.
    task automatic observe();
        wr_t e;
        if (pipe_kill) begin
            n_kill++;
            if (kill_cyc < 0) kill_cyc = cyc;
        end
        if (rat_wen) begin
            n_wen++;
            if (first_wen < 0) first_wen = cyc;
            if (wr_q.size() == 0) begin
                chk("rat_wen_unexpected", 64'(rat_wen), 64'd0);
            end else begin
                e = wr_q.pop_front();
                chk("rat_waddr", 64'(rat_waddr), 64'(e.addr));
                chk("rat_wdata", 64'(pack_wdata()), 64'(e.data));
                $display("[%0t] cyc=%0d rat write addr=%0d data=0x%07h", $time, cyc, rat_waddr, pack_wdata());
            end
        end
        if (freelist_rebuild && first_rebuild < 0) first_rebuild = cyc;
        if (redirect_valid) begin
            n_redirect++;
            if (first_redirect < 0) first_redirect = cyc;
            if (pc_q.size() == 0) chk("redirect_unexpected", 64'(redirect_valid), 64'd0);
            else                  chk("redirect_pc", 64'(redirect_pc), 64'(pc_q[0]));
        end
        if (flush_dropped) begin
            n_dropped++;
            dropped_cyc = cyc;
        end
    endtask

    // Drive inputs for the current cycle, then retire a redirect on handshake.
    task automatic drive();
        lsu_sb_empty    = (cyc >= 2 + sb_low);
        redirect_ready  = redirect_valid && (n_redirect > ready_delay);
        flush_req       = (cyc == inject_cyc);
        flush_target_pc = (cyc == inject_cyc) ? 32'hDEAD_0000 : 32'h0;
        if (redirect_valid && redirect_ready) begin
            $display("[%0t] cyc=%0d redirect accepted pc=0x%08h", $time, cyc, redirect_pc);
            void'(pc_q.pop_front());
        end
    endtask

    // Issue a flush in the current cycle (cycle T) and queue expectations.
    task automatic start_flush(input logic [XLEN-1:0] pc, input logic exc,
                               input int sbl, input int rdly, input int inj);
        wr_t e;
        kill_cyc = -1; n_kill = 0; first_wen = -1; n_wen = 0; first_rebuild = -1;
        first_redirect = -1; n_redirect = 0; n_dropped = 0; dropped_cyc = -1;
        sb_low = sbl; ready_delay = rdly; inject_cyc = inj;
        for (int r = 0; r < ARCH_REGS / RW; r++) begin
            e.addr = 5'(r * RW);
            for (int l = 0; l < RW; l++) e.data[l*PHYS_W +: PHYS_W] = crat_mem[r*RW + l];
            wr_q.push_back(e);
        end
        pc_q.push_back(pc);
        flush_req          = 1'b1;
        flush_is_exception = exc;
        flush_target_pc    = pc;
        lsu_sb_empty       = (sbl == 0);
        redirect_ready     = 1'b0;
        $display("[%0t] flush pc=0x%08h exc=%0d", $time, pc, exc);
        tick();
        flush_req          = 1'b0;
        flush_is_exception = 1'b0;
        cyc = 1;
        observe();
        drive();
    endtask

    task automatic run_recovery(input logic [XLEN-1:0] pc, input logic exc,
                                input int sbl, input int rdly, input int inj);
        int guard;
        start_flush(pc, exc, sbl, rdly, inj);
        guard = 0;
        while (busy && guard < 600) begin
            tick();
            cyc++;
            observe();
            drive();
            guard++;
        end
        chk("recovery_completes", 64'(busy), 64'd0);
        chk("scoreboard_writes_left", 64'(wr_q.size()), 64'd0);
        chk("scoreboard_pcs_left", 64'(pc_q.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},      64'(busy), 64'd0);
        chk({tag, "_stall"},     64'(frontend_stall), 64'd0);
        chk({tag, "_pipe_kill"}, 64'(pipe_kill), 64'd0);
        chk({tag, "_rat_wen"},   64'(rat_wen), 64'd0);
        chk({tag, "_rat_waddr"}, 64'(rat_waddr), 64'd0);
        chk({tag, "_rat_wdata"}, 64'(pack_wdata()), 64'd0);
        chk({tag, "_rebuild"},   64'(freelist_rebuild), 64'd0);
        chk({tag, "_rvalid"},    64'(redirect_valid), 64'd0);
        chk({tag, "_rpc"},       64'(redirect_pc), 64'd0);
        chk({tag, "_dropped"},   64'(flush_dropped), 64'd0);
        chk({tag, "_timeout"},   64'(drain_timeout), 64'd0);
        chk({tag, "_perf"},      64'(perf_recoveries), 64'd0);
        chk({tag, "_raddr"},     64'(crat_raddr), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; flush_req = 1'b0; flush_is_exception = 1'b0;
        flush_target_pc = '0; lsu_sb_empty = 1'b1; redirect_ready = 1'b0;
        cyc = 0; sb_low = 0; ready_delay = 0; inject_cyc = -1;
        for (int i = 0; i < ARCH_REGS; i++) crat_mem[i] = 7'(i + 32);

        // Reset state; a flush while in reset must be discarded.
        tick();
        flush_req = 1'b1; flush_target_pc = 32'h0000_0BAD;
        tick();
        check_all_zero("reset");
        flush_req = 1'b0; flush_target_pc = '0;
        reset_n = 1'b1;
        tick();
        chk("flush_in_reset_discarded", 64'(busy), 64'd0);

        // 1: mispredict, ready immediately, RAT arch i -> phys i+32
        run_recovery(32'h0000_2000, 1'b0, 0, 0, -1);
        chk("mp_kill_cycle", 64'(kill_cyc), 64'd1);
        chk("mp_kill_count", 64'(n_kill), 64'd1);
        chk("mp_first_wen", 64'(first_wen), 64'd3);
        chk("mp_wen_count", 64'(n_wen), 64'd8);
        chk("mp_rebuild_cycle", 64'(first_rebuild), 64'd10);
        chk("mp_redirect_cycle", 64'(first_redirect), 64'd11);
        chk("mp_redirect_count", 64'(n_redirect), 64'd1);
        chk("mp_perf", 64'(perf_recoveries), 64'd1);
        chk("mp_stall_idle", 64'(frontend_stall), 64'd0);

        // 2: exception, store buffer non-empty for 5 cycles, random RAT
        for (int i = 0; i < ARCH_REGS; i++) crat_mem[i] = 7'($urandom_range(0, 127));
        run_recovery(32'h8000_0100, 1'b1, 5, 0, -1);
        chk("exc_drain_cycles", 64'(first_wen - 3), 64'd6);
        chk("exc_wen_count", 64'(n_wen), 64'd8);
        chk("exc_rebuild_cycle", 64'(first_rebuild), 64'd16);
        chk("exc_redirect_cycle", 64'(first_redirect), 64'd17);
        chk("exc_no_timeout", 64'(drain_timeout), 64'd0);
        chk("exc_perf", 64'(perf_recoveries), 64'd2);

        // 3: exception with a wedged store buffer -> timeout after 255 cycles
        run_recovery(32'h0000_0004, 1'b1, 1000, 0, -1);
        chk("to_drain_cycles", 64'(first_wen - 3), 64'd255);
        chk("to_rebuild_cycle", 64'(first_rebuild), 64'd265);
        chk("to_timeout_set", 64'(drain_timeout), 64'd1);
        chk("to_perf", 64'(perf_recoveries), 64'd3);

        // 4: flush injected during RESTORE is dropped; redirect stalled 3 cycles
        for (int i = 0; i < ARCH_REGS; i++) crat_mem[i] = 7'(127 - i);
        run_recovery(32'h1234_5678, 1'b0, 0, 3, 5);
        chk("drop_count", 64'(n_dropped), 64'd1);
        chk("drop_cycle", 64'(dropped_cyc), 64'd6);
        chk("drop_kill_count", 64'(n_kill), 64'd1);
        chk("hold_redirect_cycles", 64'(n_redirect), 64'd4);
        chk("hold_first_redirect", 64'(first_redirect), 64'd11);
        chk("timeout_sticky", 64'(drain_timeout), 64'd1);
        chk("hold_perf", 64'(perf_recoveries), 64'd4);

        // 5: reset asserted mid-RESTORE aborts everything immediately
        start_flush(32'h0000_3000, 1'b0, 0, 0, -1);
        for (int k = 0; k < 4; k++) begin
            tick();
            cyc++;
            observe();
            drive();
        end
        chk("pre_reset_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        wr_q.delete();
        pc_q.delete();
        tick();
        reset_n = 1'b1;
        tick();

        // New flush after release runs a full sequence
        for (int i = 0; i < ARCH_REGS; i++) crat_mem[i] = 7'(i * 3 + 1);
        run_recovery(32'h2000_0040, 1'b0, 0, 0, -1);
        chk("post_reset_first_wen", 64'(first_wen), 64'd3);
        chk("post_reset_wen_count", 64'(n_wen), 64'd8);
        chk("post_reset_rebuild", 64'(first_rebuild), 64'd10);
        chk("post_reset_redirect", 64'(first_redirect), 64'd11);
        chk("post_reset_perf", 64'(perf_recoveries), 64'd1);
        chk("post_reset_timeout", 64'(drain_timeout), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
